// File: rtl/dsp_sample_bridge_pkg.sv
// Shared state type, Q5.30 clamp limits and counter width for the uDSP sample bridge.
package dsp_bridge_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN} bridge_state_t;

   localparam logic signed [35:0] Q530_POS_ONE_M1 = 36'sh0_3FFF_FFFF;
   localparam logic signed [35:0] Q530_NEG_ONE    = 36'shF_C000_0000;

   localparam int CLIP_CNT_W = 16;

endpackage

// File: rtl/dsp_sample_bridge_if.sv
// Sample streams plus the bridge-owned RAM port; master is the bridge side, slave the environment.
interface dsp_sample_bridge_if #(
   parameter int DAW = 10,
   parameter int DWW = 36
);
   import dsp_bridge_pkg::*;

   logic           in_valid;
   logic           in_ready;
   logic [DWW-1:0] in_data;
   logic           out_valid;
   logic           out_ready;
   logic [DWW-1:0] out_data;
   logic [DAW-1:0] mem_addr;
   logic [DWW-1:0] mem_wdata;
   logic           mem_we;
   logic [DWW-1:0] mem_rdata;

   modport master (
      input  in_valid, in_data, out_ready, mem_rdata,
      output in_ready, out_valid, out_data, mem_addr, mem_wdata, mem_we
   );

   modport slave (
      output in_valid, in_data, out_ready, mem_rdata,
      input  in_ready, out_valid, out_data, mem_addr, mem_wdata, mem_we
   );

endinterface

// File: rtl/dsp_sample_bridge_q530_clip.sv
// q530_clip: combinational clamp of a Q5.30 word to [-1.0, 1.0 - lsb] with a clipped flag.
// Only compiled when DSP_BRIDGE_CLIP_EN is defined, since only that build instantiates it.
`ifdef DSP_BRIDGE_CLIP_EN
module q530_clip
   import dsp_bridge_pkg::*;
#(
   parameter int DWW = 36
) (
   input  logic signed [DWW-1:0] i_word,
   output logic        [DWW-1:0] o_word,
   output logic                  o_clipped
);

   localparam logic signed [DWW-1:0] HI = DWW'(Q530_POS_ONE_M1);
   localparam logic signed [DWW-1:0] LO = DWW'(Q530_NEG_ONE);

   // Returns {clipped, word}.
   function automatic logic [DWW:0] sat_q530(input logic signed [DWW-1:0] x);
      if (x > HI) return {1'b1, HI};
      if (x < LO) return {1'b1, LO};
      return {1'b0, x};
   endfunction

   assign {o_clipped, o_word} = sat_q530(i_word);

endmodule
`endif

// File: rtl/dsp_sample_bridge.sv
// dsp_sample_bridge: loads a frame into uDSP data RAM, starts the core, waits, then streams results out.
// Optional output clamping and clip counting under `DSP_BRIDGE_CLIP_EN.
module dsp_sample_bridge
   import dsp_bridge_pkg::*;
#(
   parameter int             DAW        = 10,
   parameter int             DWW        = 36,
   parameter int             NCH_IN     = 8,
   parameter int             NCH_OUT    = 8,
   parameter logic [DAW-1:0] IN_BASE    = 10'h000,
   parameter logic [DAW-1:0] OUT_BASE   = 10'h040,
   parameter int             RUN_CYCLES = 520
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  frame_sync,
   dsp_sample_bridge_if.master   bus,
   output logic                  dsp_start,
   output logic                  busy,
   output logic                  overrun,
   output logic [CLIP_CNT_W-1:0] clip_count
);

   localparam int NCH_MAX = (NCH_IN > NCH_OUT) ? NCH_IN : NCH_OUT;
   localparam int KW      = (NCH_MAX > 1) ? $clog2(NCH_MAX) : 1;
   localparam int CW      = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

   localparam logic [KW-1:0] K_IN_LAST  = KW'(NCH_IN - 1);
   localparam logic [KW-1:0] K_OUT_LAST = KW'(NCH_OUT - 1);
   localparam logic [CW-1:0] RUN_LAST   = CW'(RUN_CYCLES - 1);

   bridge_state_t         r_state;
   logic [KW-1:0]         r_k;
   logic [CW-1:0]         r_run_cnt;
   logic                  r_prime;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic [DWW-1:0]        r_out_data;
   logic                  r_clip_flag;
   logic [DAW-1:0]        r_mem_addr;
   logic [DWW-1:0]        r_mem_wdata;
   logic                  r_mem_we;
   logic                  r_dsp_start;
   logic                  r_busy;
   logic                  r_overrun;
   logic [CLIP_CNT_W-1:0] r_clip_cnt;

   logic [DWW-1:0]        w_clip_word;
   logic                  w_clipped;

`ifdef DSP_BRIDGE_CLIP_EN
   q530_clip #(.DWW(DWW)) u_clip (
      .i_word    (bus.mem_rdata),
      .o_word    (w_clip_word),
      .o_clipped (w_clipped)
   );
`else
   assign w_clip_word = bus.mem_rdata;
   assign w_clipped   = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_k         <= '0;
         r_run_cnt   <= '0;
         r_prime     <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_clip_flag <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= 1'b0;
         r_dsp_start <= 1'b0;
         r_busy      <= 1'b0;
         r_overrun   <= 1'b0;
         r_clip_cnt  <= '0;
      end else begin
         r_mem_we    <= 1'b0;
         r_dsp_start <= 1'b0;
         if (frame_sync && (r_state != IDLE)) r_overrun <= 1'b1;

         unique case (r_state)
            IDLE: begin
               r_k <= '0;
               if (frame_sync) begin
                  r_state    <= LOAD;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            LOAD: begin
               if (bus.in_valid && r_in_ready) begin
                  r_mem_addr  <= IN_BASE + DAW'(r_k);
                  r_mem_wdata <= bus.in_data;
                  r_mem_we    <= 1'b1;
                  if (r_k == K_IN_LAST) begin
                     r_k         <= '0;
                     r_in_ready  <= 1'b0;
                     r_dsp_start <= 1'b1;
                     r_state     <= START;
                  end else begin
                     r_k <= r_k + 1'b1;
                  end
               end
            end
            START: begin
               r_run_cnt <= '0;
               r_state   <= RUN;
            end
            RUN: begin
               // The first drain read is issued on the way out so it is already on the port in DRAIN.
               if (r_run_cnt == RUN_LAST) begin
                  r_state    <= DRAIN;
                  r_k        <= '0;
                  r_prime    <= 1'b1;
                  r_mem_addr <= OUT_BASE;
               end else begin
                  r_run_cnt <= r_run_cnt + 1'b1;
               end
            end
            DRAIN: begin
               // Next read is issued when the current word is latched, hiding RAM latency behind the handshake.
               if (r_prime) begin
                  r_prime <= 1'b0;
               end else if (!r_out_valid) begin
                  r_out_data  <= w_clip_word;
                  r_clip_flag <= w_clipped;
                  r_out_valid <= 1'b1;
                  if (r_k != K_OUT_LAST) r_mem_addr <= OUT_BASE + DAW'(r_k) + 1'b1;
               end else if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  if (r_clip_flag && (r_clip_cnt != '1)) r_clip_cnt <= r_clip_cnt + 1'b1;
                  if (r_k == K_OUT_LAST) begin
                     r_k     <= '0;
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_k <= r_k + 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_we    = r_mem_we;
   assign dsp_start     = r_dsp_start;
   assign busy          = r_busy;
   assign overrun       = r_overrun;
   assign clip_count    = r_clip_cnt;

endmodule

// File: tb/tb_dsp_sample_bridge.sv
// Directed bench for dsp_sample_bridge with a dual-port RAM model that stands in for the uDSP.
`timescale 1ns/1ps
module tb_dsp_sample_bridge;
   import dsp_bridge_pkg::*;

   localparam int             DAW  = 10;
   localparam int             DWW  = 36;
   localparam int             NCH  = 8;
   localparam int             RUNC = 520;
   localparam logic [DAW-1:0] IN_BASE  = 10'h000;
   localparam logic [DAW-1:0] OUT_BASE = 10'h040;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        frame_sync = 1'b0;
   logic        dsp_start, busy, overrun;
   logic [15:0] clip_count;

   dsp_sample_bridge_if #(.DAW(DAW), .DWW(DWW)) bus();

   dsp_sample_bridge #(
      .DAW(DAW), .DWW(DWW), .NCH_IN(NCH), .NCH_OUT(NCH),
      .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE), .RUN_CYCLES(RUNC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .frame_sync(frame_sync), .bus(bus),
      .dsp_start(dsp_start), .busy(busy), .overrun(overrun), .clip_count(clip_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // RAM model: bridge port writes, registered read; the "uDSP" copies or preloads OUT during RUN.
   logic [DWW-1:0] ram [0:1023];
   logic [DWW-1:0] preload [0:NCH-1];
   logic           copy_en = 1'b1;
   logic           copy_pend = 1'b0;
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      copy_pend <= dsp_start;
      if (copy_pend)
         for (int i = 0; i < NCH; i++) ram[OUT_BASE + i] <= copy_en ? ram[IN_BASE + i] : preload[i];
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int first_hs, last_hs, first_we, n_we, ds_cnt, ds_cyc, first_ov, busy_cnt;
   logic [DAW-1:0] first_we_addr;
   logic [DWW-1:0] first_we_data;
   always @(negedge clk) begin
      if (bus.in_valid && bus.in_ready) begin
         if (first_hs < 0) first_hs = cyc;
         last_hs = cyc;
      end
      if (bus.mem_we) begin
         if (first_we < 0) begin
            first_we = cyc; first_we_addr = bus.mem_addr; first_we_data = bus.mem_wdata;
         end
         n_we++;
      end
      if (dsp_start) begin
         if (ds_cyc < 0) ds_cyc = cyc;
         ds_cnt++;
      end
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      if (busy) busy_cnt++;
   end

   task automatic clear_mon();
      first_hs = -1; last_hs = -1; first_we = -1; n_we = 0;
      ds_cnt = 0; ds_cyc = -1; first_ov = -1; busy_cnt = 0;
   endtask

   task automatic pulse_frame_sync();
      @(posedge clk); #1 frame_sync = 1'b1;
      @(posedge clk); #1 frame_sync = 1'b0;
   endtask

   task automatic feed(input logic [DWW-1:0] base, input int count, output int sent);
      logic hs;
      sent = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = base;
      for (int g = 0; g < 50 && sent < count; g++) begin
         @(negedge clk); hs = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (hs) begin
            sent++;
            bus.in_data = base + DWW'(sent);
         end
      end
      bus.in_valid = 1'b0;
   endtask

   logic [DWW-1:0] got [0:NCH-1];
   int             n_got;
   task automatic collect(input int budget);
      n_got = 0;
      for (int g = 0; g < budget && n_got < NCH; g++) begin
         @(negedge clk);
         bus.out_ready = 1'b1;
         if (bus.out_valid) begin
            got[n_got] = bus.out_data;
            n_got++;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
      n_checks++; if (dsp_start !== 1'b0) begin n_fail++; $display("FAIL rst_dsp_start: got %b want 0", dsp_start); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b want 0", overrun); end
      n_checks++; if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
      n_checks++; if (bus.mem_wdata !== '0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata); end
      n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
      n_checks++; if (clip_count !== 16'h0) begin n_fail++; $display("FAIL rst_clip_count: got %h want 0", clip_count); end
      @(negedge clk) reset_n = 1'b1;
   endtask

   task automatic test_normal_frame();
      int sent;
      copy_en = 1'b1;
      clear_mon();
      pulse_frame_sync();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL norm_busy_hi: got %b want 1", busy); end
      feed(36'd1, NCH, sent);
      n_checks++; if (sent != NCH) begin n_fail++; $display("FAIL norm_load_count: got %0d want %0d", sent, NCH); end
      collect(800);
      n_checks++; if (n_got != NCH) begin n_fail++; $display("FAIL norm_out_count: got %0d want %0d", n_got, NCH); end
      for (int i = 0; i < n_got; i++) begin
         n_checks++; if (got[i] !== DWW'(i + 1)) begin n_fail++; $display("FAIL norm_out[%0d]: got %h want %h", i, got[i], DWW'(i + 1)); end
      end
      for (int i = 0; i < NCH; i++) begin
         n_checks++; if (ram[IN_BASE + i] !== DWW'(i + 1)) begin n_fail++; $display("FAIL norm_ram_in[%0d]: got %h want %h", i, ram[IN_BASE + i], DWW'(i + 1)); end
      end
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL norm_busy_lo: got %b want 0", busy); end
      n_checks++; if (ds_cnt != 1) begin n_fail++; $display("FAIL norm_start_width: got %0d want 1", ds_cnt); end
      n_checks++; if (ds_cyc != last_hs + 1) begin n_fail++; $display("FAIL norm_start_lat: got %0d want %0d", ds_cyc, last_hs + 1); end
      n_checks++; if (first_we != first_hs + 1) begin n_fail++; $display("FAIL norm_write_lat: got %0d want %0d", first_we, first_hs + 1); end
      n_checks++; if (n_we != NCH) begin n_fail++; $display("FAIL norm_write_count: got %0d want %0d", n_we, NCH); end
      n_checks++; if (first_we_addr !== IN_BASE) begin n_fail++; $display("FAIL norm_first_addr: got %h want %h", first_we_addr, IN_BASE); end
      n_checks++; if (first_ov != ds_cyc + RUNC + 3) begin n_fail++; $display("FAIL norm_drain_lat: got %0d want %0d", first_ov, ds_cyc + RUNC + 3); end
      n_checks++; if (busy_cnt != 3 * NCH + RUNC + 2) begin n_fail++; $display("FAIL norm_frame_time: got %0d want %0d", busy_cnt, 3 * NCH + RUNC + 2); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL norm_overrun: got %b want 0", overrun); end
   endtask

   task automatic test_backpressure();
      int sent, idx, stall;
      logic [DWW-1:0] held;
      copy_en = 1'b1;
      clear_mon();
      pulse_frame_sync();
      feed(36'h10, NCH, sent);
      idx = 0; stall = 0; held = '0;
      for (int g = 0; g < 800 && idx < NCH; g++) begin
         @(negedge clk);
         if (idx == 2 && stall < 5 && (stall > 0 || bus.out_valid)) begin
            bus.out_ready = 1'b0;
            if (stall == 0) begin
               held = bus.out_data;
            end else begin
               n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", stall, bus.out_valid); end
               n_checks++; if (bus.out_data !== held) begin n_fail++; $display("FAIL bp_data_hold[%0d]: got %h want %h", stall, bus.out_data, held); end
            end
            stall++;
         end else begin
            bus.out_ready = 1'b1;
            if (bus.out_valid) begin
               got[idx] = bus.out_data;
               idx++;
            end
         end
      end
      bus.out_ready = 1'b1;
      n_checks++; if (held !== 36'h12) begin n_fail++; $display("FAIL bp_held_value: got %h want 12", held); end
      n_checks++; if (idx != NCH) begin n_fail++; $display("FAIL bp_out_count: got %0d want %0d", idx, NCH); end
      for (int i = 0; i < idx; i++) begin
         n_checks++; if (got[i] !== 36'h10 + DWW'(i)) begin n_fail++; $display("FAIL bp_out[%0d]: got %h want %h", i, got[i], 36'h10 + DWW'(i)); end
      end
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_lo: got %b want 0", busy); end
   endtask

   task automatic test_overrun();
      int sent;
      copy_en = 1'b1;
      clear_mon();
      pulse_frame_sync();
      feed(36'h20, NCH, sent);
      repeat (10) @(posedge clk);
      #1 frame_sync = 1'b1;
      @(posedge clk); #1 frame_sync = 1'b0;
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovr_busy: got %b want 1", busy); end
      collect(800);
      n_checks++; if (n_got != NCH) begin n_fail++; $display("FAIL ovr_out_count: got %0d want %0d", n_got, NCH); end
      for (int i = 0; i < n_got; i++) begin
         n_checks++; if (got[i] !== 36'h20 + DWW'(i)) begin n_fail++; $display("FAIL ovr_out[%0d]: got %h want %h", i, got[i], 36'h20 + DWW'(i)); end
      end
      repeat (30) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_no_second_frame: busy got %b want 0", busy); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL ovr_in_ready: got %b want 0", bus.in_ready); end
      n_checks++; if (ds_cnt != 1) begin n_fail++; $display("FAIL ovr_start_count: got %0d want 1", ds_cnt); end
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
   endtask

   task automatic test_reset_midload();
      int sent;
      copy_en = 1'b1;
      pulse_frame_sync();
      feed(36'h30, 3, sent);
      n_checks++; if (sent != 3) begin n_fail++; $display("FAIL mid_load_count: got %0d want 3", sent); end
      #2 reset_n = 1'b0;
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b want 0", bus.in_ready); end
      n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_mem_we: got %b want 0", bus.mem_we); end
      n_checks++; if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL mid_mem_addr: got %h want 0", bus.mem_addr); end
      n_checks++; if (bus.mem_wdata !== '0) begin n_fail++; $display("FAIL mid_mem_wdata: got %h want 0", bus.mem_wdata); end
      n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL mid_out_data: got %h want 0", bus.out_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL mid_overrun: got %b want 0", overrun); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      clear_mon();
      pulse_frame_sync();
      feed(36'h40, NCH, sent);
      collect(800);
      n_checks++; if (first_we_addr !== IN_BASE) begin n_fail++; $display("FAIL mid_restart_addr: got %h want %h", first_we_addr, IN_BASE); end
      n_checks++; if (first_we_data !== 36'h40) begin n_fail++; $display("FAIL mid_restart_data: got %h want 40", first_we_data); end
      n_checks++; if (n_got != NCH) begin n_fail++; $display("FAIL mid_out_count: got %0d want %0d", n_got, NCH); end
      for (int i = 0; i < n_got; i++) begin
         n_checks++; if (got[i] !== 36'h40 + DWW'(i)) begin n_fail++; $display("FAIL mid_out[%0d]: got %h want %h", i, got[i], 36'h40 + DWW'(i)); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_clip();
      int sent;
      logic [DWW-1:0] exp_out [0:NCH-1];
      logic [15:0]    exp_cnt;
      preload[0] = 36'h0_8000_0000; preload[1] = 36'hF_0000_0000;
      preload[2] = 36'h0_0000_0005; preload[3] = 36'hF_FFFF_FFFB;
      preload[4] = 36'h0_3FFF_FFFF; preload[5] = 36'hF_C000_0000;
      preload[6] = 36'h0_4000_0000; preload[7] = 36'hF_BFFF_FFFF;
`ifdef DSP_BRIDGE_CLIP_EN
      exp_out[0] = 36'h0_3FFF_FFFF; exp_out[1] = 36'hF_C000_0000;
      exp_out[2] = 36'h0_0000_0005; exp_out[3] = 36'hF_FFFF_FFFB;
      exp_out[4] = 36'h0_3FFF_FFFF; exp_out[5] = 36'hF_C000_0000;
      exp_out[6] = 36'h0_3FFF_FFFF; exp_out[7] = 36'hF_C000_0000;
      exp_cnt = 16'd4;
`else
      for (int i = 0; i < NCH; i++) exp_out[i] = preload[i];
      exp_cnt = 16'd0;
`endif
      @(negedge clk) reset_n = 1'b0;
      @(negedge clk) reset_n = 1'b1;
      copy_en = 1'b0;
      pulse_frame_sync();
      feed(36'h50, NCH, sent);
      collect(800);
      n_checks++; if (n_got != NCH) begin n_fail++; $display("FAIL clip_out_count: got %0d want %0d", n_got, NCH); end
      for (int i = 0; i < n_got; i++) begin
         n_checks++; if (got[i] !== exp_out[i]) begin n_fail++; $display("FAIL clip_out[%0d]: got %h want %h", i, got[i], exp_out[i]); end
      end
      @(posedge clk); #1;
      n_checks++; if (clip_count !== exp_cnt) begin n_fail++; $display("FAIL clip_count: got %0d want %0d", clip_count, exp_cnt); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clip_busy_lo: got %b want 0", busy); end
      copy_en = 1'b1;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < NCH; i++) preload[i] = '0;
      clear_mon();
      test_reset();
      test_normal_frame();
      test_backpressure();
      test_overrun();
      test_reset_midload();
      test_clip();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog expired");
   end

endmodule
